// File: rtl/pwm_light_pkg.sv
// Shared mode encoding and default sizing for the PWM light controller.
package pwm_light_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_MANUAL = 2'd1,
        MODE_FADE   = 2'd2,
        MODE_BAD    = 2'd3
    } mode_e;

    localparam int DUTY_W_DEF = 8;
    localparam int STEP_DEF   = 32;

endpackage

// File: rtl/pwm_light_ctrl_pwm_gen.sv
// PWM generator: prescaler, period counter and a shadow duty reloaded only at wrap.
// Build option PWM_LIGHT_GAMMA_EN applies a (d*d)>>DUTY_W curve to the shadow load.
module pwm_gen
    import pwm_light_pkg::*;
#(
    parameter int DUTY_W  = DUTY_W_DEF,
    parameter int PWM_DIV = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm,
    output logic              period_start
);

    localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_DIV - 1);

    logic [PRE_W-1:0]  prescale;
    logic [DUTY_W-1:0] counter;
    logic [DUTY_W-1:0] shadow;
    logic [DUTY_W-1:0] duty_load;
    logic              tick;
    logic              wrap;

    assign tick = (prescale == PRE_LAST);
    assign wrap = tick && (counter == '1);

`ifdef PWM_LIGHT_GAMMA_EN
    logic [2*DUTY_W-1:0] duty_sq;
    assign duty_sq   = {{DUTY_W{1'b0}}, duty} * {{DUTY_W{1'b0}}, duty};
    assign duty_load = DUTY_W'(duty_sq >> DUTY_W);
`else
    assign duty_load = duty;
`endif

    // Shadow only changes as the counter returns to 0, so a period is never cut short.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            prescale     <= '0;
            counter      <= '0;
            shadow       <= '0;
            pwm          <= 1'b0;
            period_start <= 1'b0;
        end else begin
            prescale     <= tick ? '0 : prescale + 1'b1;
            if (tick) begin
                counter <= counter + 1'b1;
            end
            if (wrap) begin
                shadow <= duty_load;
            end
            period_start <= wrap;
            pwm          <= (counter < shadow);
        end
    end

endmodule

// File: rtl/pwm_light_ctrl.sv
// Mode/brightness controller (OFF, MANUAL, FADE) feeding pwm_gen.
// Optional build macro: PWM_LIGHT_GAMMA_EN (gamma-corrected shadow duty inside pwm_gen).
module pwm_light_ctrl
    import pwm_light_pkg::*;
#(
    parameter int DUTY_W        = DUTY_W_DEF,
    parameter int PWM_DIV       = 4,
    parameter int STEP          = STEP_DEF,
    parameter int DEFAULT_LEVEL = 128,
    parameter int FADE_TICK     = 100_000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_btn_up,
    input  logic              i_btn_down,
    input  logic              i_btn_mode,
    output logic              o_pwm,
    output logic [DUTY_W-1:0] o_duty,
    output logic [1:0]        o_mode,
    output logic              o_period_start
);

    localparam int FT_W = (FADE_TICK > 1) ? $clog2(FADE_TICK) : 1;
    localparam logic [FT_W-1:0]   FT_LAST   = FT_W'(FADE_TICK - 1);
    localparam logic [DUTY_W-1:0] MAX_LEVEL = '1;

    mode_e             mode;
    logic [DUTY_W-1:0] level;
    logic [DUTY_W-1:0] fade_val;
    logic              fade_down;
    logic [FT_W-1:0]   fade_cnt;
    logic [DUTY_W:0]   level_up;
    logic [DUTY_W:0]   level_dn;
    logic [DUTY_W-1:0] level_inc;
    logic [DUTY_W-1:0] level_dec;

    // One extra bit catches overflow/borrow so the level saturates instead of wrapping.
    assign level_up = {1'b0, level} + (DUTY_W + 1)'(STEP);
    assign level_dn = {1'b0, level} - (DUTY_W + 1)'(STEP);

    always_comb begin
        level_inc = level_up[DUTY_W] ? MAX_LEVEL : level_up[DUTY_W-1:0];
        level_dec = level_dn[DUTY_W] ? '0 : level_dn[DUTY_W-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            mode      <= MODE_OFF;
            level     <= DUTY_W'(DEFAULT_LEVEL);
            fade_val  <= '0;
            fade_down <= 1'b0;
            fade_cnt  <= '0;
        end else if (i_btn_mode) begin
            case (mode)
                MODE_OFF:    mode <= MODE_MANUAL;
                MODE_MANUAL: begin
                    mode      <= MODE_FADE;
                    fade_val  <= level;
                    fade_down <= 1'b0;
                    fade_cnt  <= '0;
                end
                default:     mode <= MODE_OFF;
            endcase
        end else begin
            case (mode)
                MODE_MANUAL: begin
                    if (i_btn_up && !i_btn_down) begin
                        level <= level_inc;
                    end else if (i_btn_down && !i_btn_up) begin
                        level <= level_dec;
                    end
                end
                MODE_FADE: begin
                    // Reaching an endpoint spends one tick turning around, so it is held one tick.
                    if (fade_cnt == FT_LAST) begin
                        fade_cnt <= '0;
                        if (!fade_down) begin
                            if (fade_val == MAX_LEVEL) fade_down <= 1'b1;
                            else                       fade_val  <= fade_val + 1'b1;
                        end else begin
                            if (fade_val == '0) fade_down <= 1'b0;
                            else                fade_val  <= fade_val - 1'b1;
                        end
                    end else begin
                        fade_cnt <= fade_cnt + 1'b1;
                    end
                end
                MODE_BAD:    mode <= MODE_OFF;
                default:     ;
            endcase
        end
    end

    always_comb begin
        case (mode)
            MODE_MANUAL: o_duty = level;
            MODE_FADE:   o_duty = fade_val;
            default:     o_duty = '0;
        endcase
    end

    assign o_mode = mode;

    pwm_gen #(
        .DUTY_W  (DUTY_W),
        .PWM_DIV (PWM_DIV)
    ) u_pwm_gen (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .duty         (o_duty),
        .pwm          (o_pwm),
        .period_start (o_period_start)
    );

endmodule

// File: tb/tb_pwm_light_ctrl.sv
// Bench for pwm_light_ctrl: directed scenarios plus random pulses, checked every cycle
// against an arithmetic model of modes, level, fade and PWM timing.
module tb_pwm_light_ctrl;

    localparam int DUTY_W        = 8;
    localparam int PWM_DIV       = 1;
    localparam int STEP          = 32;
    localparam int DEFAULT_LEVEL = 128;
    localparam int FADE_TICK     = 4;
    localparam int MAXV          = (1 << DUTY_W) - 1;
    localparam int PERIOD        = 1 << DUTY_W;
`ifdef PWM_LIGHT_GAMMA_EN
    localparam int EXP_HIGH_128  = 64;
`else
    localparam int EXP_HIGH_128  = 128;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              btn_up = 1'b0;
    logic              btn_down = 1'b0;
    logic              btn_mode = 1'b0;
    logic              pwm;
    logic              period_start;
    logic [DUTY_W-1:0] duty;
    logic [1:0]        mode;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pwm_light_ctrl #(
        .DUTY_W        (DUTY_W),
        .PWM_DIV       (PWM_DIV),
        .STEP          (STEP),
        .DEFAULT_LEVEL (DEFAULT_LEVEL),
        .FADE_TICK     (FADE_TICK)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_btn_up       (btn_up),
        .i_btn_down     (btn_down),
        .i_btn_mode     (btn_mode),
        .o_pwm          (pwm),
        .o_duty         (duty),
        .o_mode         (mode),
        .o_period_start (period_start)
    );

    // Reference state: plain integers, cycle count since reset drives the PWM position.
    int m_mode, m_level, m_fval, m_fdir, m_fcnt, m_n, m_shadow, m_pwm, m_pstart;
    bit model_valid = 1'b0;

    function automatic int gamma_of(int d);
`ifdef PWM_LIGHT_GAMMA_EN
        return (d * d) >> DUTY_W;
`else
        return d;
`endif
    endfunction

    function automatic int target_duty();
        if (m_mode == 1) return m_level;
        if (m_mode == 2) return m_fval;
        return 0;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    always @(posedge clk) begin : model_step
        int dnow;
        int cnt_prev;
        if (reset) begin
            m_mode = 0; m_level = DEFAULT_LEVEL; m_fval = 0; m_fdir = 1; m_fcnt = 0;
            m_n = 0; m_shadow = 0; m_pwm = 0; m_pstart = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            cnt_prev = (m_n / PWM_DIV) % PERIOD;
            dnow     = target_duty();
            m_pwm    = (cnt_prev < m_shadow) ? 1 : 0;
            m_n++;
            m_pstart = ((m_n % (PERIOD * PWM_DIV)) == 0) ? 1 : 0;
            if (m_pstart == 1) m_shadow = gamma_of(dnow);
            if (btn_mode) begin
                if (m_mode == 1) begin
                    m_fval = m_level; m_fdir = 1; m_fcnt = 0;
                end
                m_mode = (m_mode + 1) % 3;
            end else if (m_mode == 1) begin
                if (btn_up && !btn_down)
                    m_level = (m_level + STEP > MAXV) ? MAXV : m_level + STEP;
                else if (btn_down && !btn_up)
                    m_level = (m_level < STEP) ? 0 : m_level - STEP;
            end else if (m_mode == 2) begin
                m_fcnt++;
                if (m_fcnt == FADE_TICK) begin
                    m_fcnt = 0;
                    if (m_fval + m_fdir > MAXV || m_fval + m_fdir < 0) m_fdir = -m_fdir;
                    else m_fval = m_fval + m_fdir;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("mode", int'(mode), m_mode);
            checkOutput("duty", int'(duty), target_duty());
            checkOutput("pwm", int'(pwm), m_pwm);
            checkOutput("period_start", int'(period_start), m_pstart);
        end
    end

    task automatic applyStimulus(input bit up, input bit down, input bit md);
        btn_up = up; btn_down = down; btn_mode = md;
        @(posedge clk); #1;
        btn_up = 1'b0; btn_down = 1'b0; btn_mode = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin : stimulus
        int highs;
        int waited;
        int up_exp[5]   = '{160, 192, 224, 255, 255};
        int down_exp[9] = '{223, 191, 159, 127, 95, 63, 31, 0, 0};

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        highs = 0;
        repeat (600) begin
            @(posedge clk); #1;
            if (pwm) highs++;
        end
        checkOutput("idle_pwm_highs", highs, 0);
        checkOutput("idle_mode", int'(mode), 0);
        checkOutput("idle_duty", int'(duty), 0);

        applyStimulus(0, 0, 1);
        checkOutput("manual_entry_mode", int'(mode), 1);
        checkOutput("manual_entry_duty", int'(duty), 128);

        waited = 0;
        while (!period_start && waited < 2 * PERIOD * PWM_DIV) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!period_start) begin
            checks++;
            failures++;
            $display("[TB] FAIL period_start_wait: got no pulse, expected one within %0d cycles", waited);
        end else begin
            highs = 0;
            repeat (PERIOD * PWM_DIV) begin
                @(posedge clk); #1;
                if (pwm) highs++;
            end
            checkOutput("manual_period_highs", highs, EXP_HIGH_128);
        end

        foreach (up_exp[i]) begin
            applyStimulus(1, 0, 0);
            checkOutput("manual_up", int'(duty), up_exp[i]);
        end
        foreach (down_exp[i]) begin
            applyStimulus(0, 1, 0);
            checkOutput("manual_down", int'(duty), down_exp[i]);
        end

        applyStimulus(1, 1, 0);
        checkOutput("updown_same_at0", int'(duty), 0);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 0);
        checkOutput("updown_same_at32", int'(duty), 32);
        applyStimulus(1, 0, 1);
        checkOutput("mode_beats_up_mode", int'(mode), 2);
        checkOutput("mode_beats_up_duty", int'(duty), 32);
        applyStimulus(0, 0, 1);
        checkOutput("fade_to_off_duty", int'(duty), 0);
        applyStimulus(0, 0, 1);
        checkOutput("off_to_manual_level", int'(duty), 32);

        repeat (6) applyStimulus(1, 0, 0);
        checkOutput("manual_level_224", int'(duty), 224);

        applyStimulus(0, 0, 1);
        checkOutput("fade_entry", int'(duty), 224);
        idle(4);
        checkOutput("fade_first_step", int'(duty), 225);
        applyStimulus(1, 0, 0);
        idle(119);
        checkOutput("fade_reach_top", int'(duty), 255);
        idle(4);
        checkOutput("fade_hold_top", int'(duty), 255);
        idle(4);
        checkOutput("fade_turn_down", int'(duty), 254);
        applyStimulus(0, 0, 1);
        checkOutput("fade_exit_off", int'(duty), 0);
        applyStimulus(0, 0, 1);
        checkOutput("level_restored", int'(duty), 224);

        repeat (4000) begin
            reset    = ($urandom_range(0, 1499) == 0);
            btn_mode = ($urandom_range(0, 39) == 0);
            btn_up   = ($urandom_range(0, 7) == 0);
            btn_down = ($urandom_range(0, 7) == 0);
            @(posedge clk); #1;
        end
        reset = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_mode = 1'b0;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
